// File: rtl/wb_master_bridge.sv
// Wishbone classic single-access master: each accepted command becomes one bus cycle,
// and its read data (or a timeout error) comes back on a valid/ready response stream.
module wb_master_bridge #(
  parameter int TIMEOUT = 255,
  parameter int TW      = $clog2(TIMEOUT + 1)
) (
  input  logic        wb_clk_i,
  input  logic        wb_rst_i,
  input  logic        cmd_valid_i,
  output logic        cmd_ready_o,
  input  logic        cmd_we_i,
  input  logic [3:0]  cmd_sel_i,
  input  logic [31:0] cmd_adr_i,
  input  logic [31:0] cmd_dat_i,
  output logic        rsp_valid_o,
  input  logic        rsp_ready_i,
  output logic [31:0] rsp_dat_o,
  output logic        rsp_err_o,
  output logic        wbm_cyc_o,
  output logic        wbm_stb_o,
  output logic        wbm_we_o,
  output logic [3:0]  wbm_sel_o,
  output logic [31:0] wbm_adr_o,
  output logic [31:0] wbm_dat_o,
  input  logic        wbm_ack_i,
  input  logic [31:0] wbm_dat_i
);
  typedef enum logic [1:0] {IDLE = 2'd0, BUS = 2'd1, RESP = 2'd2} state_t;

  state_t        state, state_nxt;
  logic [TW-1:0] wait_cnt, wait_cnt_nxt;
  logic          accept, acked, expired;

  logic          cmd_ready_nxt, rsp_valid_nxt, rsp_err_nxt, cyc_nxt, we_nxt;
  logic [3:0]    sel_nxt;
  logic [31:0]   adr_nxt, dat_nxt, rsp_dat_nxt;

  assign accept  = (state == IDLE) && cmd_valid_i && cmd_ready_o;
  assign acked   = (state == BUS) && wbm_ack_i;
  // Counter holds the number of ack-less cycles already spent, so cyc stays up TIMEOUT cycles.
  assign expired = (state == BUS) && (wait_cnt == TW'(TIMEOUT - 1));

  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      state       <= IDLE;
      wait_cnt    <= '0;
      cmd_ready_o <= 1'b1;
      rsp_valid_o <= 1'b0;
      rsp_dat_o   <= '0;
      rsp_err_o   <= 1'b0;
      wbm_cyc_o   <= 1'b0;
      wbm_stb_o   <= 1'b0;
      wbm_we_o    <= 1'b0;
      wbm_sel_o   <= '0;
      wbm_adr_o   <= '0;
      wbm_dat_o   <= '0;
    end else begin
      state       <= state_nxt;
      wait_cnt    <= wait_cnt_nxt;
      cmd_ready_o <= cmd_ready_nxt;
      rsp_valid_o <= rsp_valid_nxt;
      rsp_dat_o   <= rsp_dat_nxt;
      rsp_err_o   <= rsp_err_nxt;
      wbm_cyc_o   <= cyc_nxt;
      wbm_stb_o   <= cyc_nxt;
      wbm_we_o    <= we_nxt;
      wbm_sel_o   <= sel_nxt;
      wbm_adr_o   <= adr_nxt;
      wbm_dat_o   <= dat_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (accept) state_nxt = BUS;
      BUS:     if (acked || expired) state_nxt = RESP;
      RESP:    if (rsp_ready_i) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Outputs are registered, so their next values follow the next state.
  always_comb begin
    cmd_ready_nxt = (state_nxt == IDLE);
    cyc_nxt       = (state_nxt == BUS);
    rsp_valid_nxt = (state_nxt == RESP);
    we_nxt        = wbm_we_o;
    sel_nxt       = wbm_sel_o;
    adr_nxt       = wbm_adr_o;
    dat_nxt       = wbm_dat_o;
    rsp_dat_nxt   = rsp_dat_o;
    rsp_err_nxt   = rsp_err_o;
    wait_cnt_nxt  = wait_cnt;
    if (accept) begin
      we_nxt       = cmd_we_i;
      sel_nxt      = cmd_sel_i;
      adr_nxt      = cmd_adr_i;
      dat_nxt      = cmd_dat_i;
      wait_cnt_nxt = '0;
    end
    if (acked) begin
      rsp_dat_nxt = wbm_we_o ? '0 : wbm_dat_i;
      rsp_err_nxt = 1'b0;
    end else if (expired) begin
      rsp_dat_nxt = '0;
      rsp_err_nxt = 1'b1;
    end else if (state == BUS) begin
      wait_cnt_nxt = wait_cnt + TW'(1);
    end
  end
endmodule

// File: tb/tb_wb_master_bridge.sv
// Bench for wb_master_bridge: a transaction-level reference model predicts every output
// each cycle, a slave memory answers the bus, and directed plus random traffic drives it.
module tb_wb_master_bridge;
  localparam int TIMEOUT = 8;

  logic        clk, rst;
  logic        cmd_valid, cmd_we, rsp_ready;
  logic [3:0]  cmd_sel;
  logic [31:0] cmd_adr, cmd_dat;
  logic        cmd_ready, rsp_valid, rsp_err;
  logic [31:0] rsp_dat;
  logic        cyc, stb, we;
  logic [3:0]  sel;
  logic [31:0] adr, dat;
  logic        slv_ack, spur_ack, force_ack, ack;
  logic [31:0] slv_dat;
  int          slv_wait;

  assign ack = slv_ack | spur_ack | force_ack;

  wb_master_bridge #(.TIMEOUT(TIMEOUT)) dut (
    .wb_clk_i(clk), .wb_rst_i(rst),
    .cmd_valid_i(cmd_valid), .cmd_ready_o(cmd_ready), .cmd_we_i(cmd_we),
    .cmd_sel_i(cmd_sel), .cmd_adr_i(cmd_adr), .cmd_dat_i(cmd_dat),
    .rsp_valid_o(rsp_valid), .rsp_ready_i(rsp_ready), .rsp_dat_o(rsp_dat), .rsp_err_o(rsp_err),
    .wbm_cyc_o(cyc), .wbm_stb_o(stb), .wbm_we_o(we), .wbm_sel_o(sel),
    .wbm_adr_o(adr), .wbm_dat_o(dat), .wbm_ack_i(ack), .wbm_dat_i(slv_dat)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc_no   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, required %0h (cycle %0d)", name, act, exp, cyc_no);
    end
  endtask

  function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] nw,
                                        input logic [3:0] s);
    logic [31:0] r;
    r = old;
    for (int b = 0; b < 4; b++) if (s[b]) r[8*b +: 8] = nw[8*b +: 8];
    return r;
  endfunction

  logic [31:0] mem [64];
  logic [31:0] ref_mem [64];

  // Reference model: expected outputs after each edge, from the transaction rules.
  logic        e_cmd_ready, e_cyc, e_we, e_rsp_valid, e_rsp_err;
  logic [3:0]  e_sel;
  logic [31:0] e_adr, e_dat, e_rsp_dat;
  int          bus_cycles;

  task automatic model_step();
    if (rst) begin
      e_cmd_ready = 1'b1; e_cyc = 1'b0; e_we = 1'b0; e_sel = '0; e_adr = '0; e_dat = '0;
      e_rsp_valid = 1'b0; e_rsp_dat = '0; e_rsp_err = 1'b0;
    end else if (e_rsp_valid) begin
      if (rsp_ready) begin
        e_rsp_valid = 1'b0;
        e_cmd_ready = 1'b1;
      end
    end else if (e_cyc) begin
      bus_cycles++;
      if (ack || bus_cycles == TIMEOUT) begin
        e_cyc       = 1'b0;
        e_rsp_valid = 1'b1;
        e_rsp_err   = !ack;
        e_rsp_dat   = (ack && !e_we) ? slv_dat : 32'h0;
      end
    end else if (cmd_valid) begin
      e_cmd_ready = 1'b0; e_cyc = 1'b1; bus_cycles = 0;
      e_we = cmd_we; e_sel = cmd_sel; e_adr = cmd_adr; e_dat = cmd_dat;
    end
  endtask

  initial begin
    forever begin
      @(posedge clk);
      cyc_no++;
      model_step();
    end
  end

  initial begin
    @(posedge clk);
    forever begin
      @(negedge clk);
      check("cmd_ready", cmd_ready, e_cmd_ready);
      check("cyc", cyc, e_cyc);
      check("stb", stb, e_cyc);
      check("we", we, e_we);
      check("sel", sel, e_sel);
      check("adr", adr, e_adr);
      check("dat", dat, e_dat);
      check("rsp_valid", rsp_valid, e_rsp_valid);
      if (e_rsp_valid) begin
        check("rsp_dat", rsp_dat, e_rsp_dat);
        check("rsp_err", rsp_err, e_rsp_err);
      end
    end
  end

  // Slave: acks after slv_wait wait states, reads/writes mem, drives junk data otherwise.
  initial begin
    int wcnt;
    wcnt = 0; slv_ack = 1'b0; slv_dat = '0;
    forever begin
      @(posedge clk); #1;
      slv_ack = 1'b0;
      if (cyc && stb) begin
        if (wcnt == slv_wait) begin
          slv_ack = 1'b1;
          if (we) mem[adr[7:2]] = merge(mem[adr[7:2]], dat, sel);
        end else wcnt++;
      end else wcnt = 0;
      slv_dat = (slv_ack && !we) ? mem[adr[7:2]] : $urandom;
    end
  end

  int cyc_runs[$];
  initial begin
    int run;
    run = 0;
    forever begin
      @(negedge clk);
      if (cyc) run++;
      else if (run > 0) begin
        cyc_runs.push_back(run);
        run = 0;
      end
    end
  end

  typedef struct { logic [31:0] d; logic e; int at; } rsp_t;
  rsp_t rsp_log[$];
  initial begin
    forever begin
      @(negedge clk);
      if (rsp_valid && rsp_ready) rsp_log.push_back('{d: rsp_dat, e: rsp_err, at: cyc_no});
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete, %0d failures so far", n_fail);
    $fatal(1, "watchdog");
  end

  task automatic send_cmd(input logic w, input logic [3:0] s, input logic [31:0] a,
                          input logic [31:0] d, input bit keep, output int acc);
    int n;
    n = 0;
    cmd_valid = 1'b1; cmd_we = w; cmd_sel = s; cmd_adr = a; cmd_dat = d;
    @(negedge clk);
    while (!cmd_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    check("accept_wait", cmd_ready, 1);
    @(posedge clk); #1;
    acc = cyc_no;
    if (!keep) cmd_valid = 1'b0;
  endtask

  task automatic txn(input logic w, input logic [3:0] s, input logic [31:0] a, input logic [31:0] d,
                     input int wait_n, input int hold,
                     output logic [31:0] got_dat, output logic got_err, output int got_len);
    int idx, acc, n, exp_len;
    logic [31:0] exp_dat;
    logic exp_err;
    idx     = int'(a[7:2]);
    exp_err = (wait_n >= TIMEOUT);
    exp_len = exp_err ? TIMEOUT : wait_n + 1;
    exp_dat = (exp_err || w) ? 32'h0 : ref_mem[idx];
    if (w && !exp_err) ref_mem[idx] = merge(ref_mem[idx], d, s);
    slv_wait = wait_n; rsp_ready = 1'b0;
    cyc_runs.delete();
    send_cmd(w, s, a, d, 1'b0, acc);
    @(negedge clk);
    check("bus_cyc_stb", cyc & stb, 1);
    check("bus_we", we, w);
    check("bus_sel", sel, s);
    check("bus_adr", adr, a);
    check("bus_dat", dat, d);
    n = 0;
    while (!rsp_valid && n < TIMEOUT + 10) begin
      @(negedge clk);
      n++;
    end
    check("rsp_seen", rsp_valid, 1);
    check("rsp_latency", cyc_no - acc, exp_len);
    check("txn_dat", rsp_dat, exp_dat);
    check("txn_err", rsp_err, exp_err);
    got_dat = rsp_dat;
    got_err = rsp_err;
    repeat (hold) begin
      @(posedge clk); #1;
      spur_ack = 1'($urandom_range(0, 1));
      @(negedge clk);
      check("bp_valid", rsp_valid, 1);
      check("bp_dat", rsp_dat, exp_dat);
      check("bp_err", rsp_err, exp_err);
      check("bp_cmd_ready", cmd_ready, 0);
    end
    @(posedge clk); #1;
    spur_ack = 1'b0; rsp_ready = 1'b1;
    @(posedge clk); #1;
    rsp_ready = 1'b0;
    got_len = (cyc_runs.size() > 0) ? cyc_runs[$] : -1;
    check("cyc_len", got_len, exp_len);
  endtask

  initial begin
    logic [31:0] d;
    logic        e;
    int          len, acc, idx, wsel, r;
    int          bidx[4], bacc[4];
    logic        rw;
    logic [3:0]  rs;

    rst = 1'b1; cmd_valid = 1'b0; cmd_we = 1'b0; cmd_sel = '0; cmd_adr = '0; cmd_dat = '0;
    rsp_ready = 1'b0; spur_ack = 1'b0; force_ack = 1'b0; slv_wait = 0;
    for (int i = 0; i < 64; i++) begin
      mem[i]     = $urandom;
      ref_mem[i] = mem[i];
    end
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_cmd_ready", cmd_ready, 1);
    check("rst_cyc", cyc, 0);
    check("rst_stb", stb, 0);
    check("rst_we", we, 0);
    check("rst_sel", sel, 0);
    check("rst_adr", adr, 0);
    check("rst_dat", dat, 0);
    check("rst_rsp_valid", rsp_valid, 0);
    check("rst_rsp_dat", rsp_dat, 0);
    check("rst_rsp_err", rsp_err, 0);
    @(posedge clk); #1;
    rst = 1'b0;

    // Zero-wait write.
    txn(1'b1, 4'hF, 32'h3000_0004, 32'hA5A5_1234, 0, 0, d, e, len);
    check("wr_dat", d, 32'h0);
    check("wr_err", e, 0);
    check("wr_len", len, 1);
    check("wr_mem", mem[1], 32'hA5A5_1234);

    // Read with three wait states.
    mem[5] = 32'hCAFE_F00D; ref_mem[5] = 32'hCAFE_F00D;
    txn(1'b0, 4'hF, 32'h3000_0014, 32'h1111_2222, 3, 0, d, e, len);
    check("rd_dat", d, 32'hCAFE_F00D);
    check("rd_err", e, 0);
    check("rd_len", len, 4);

    // Slave that never acks, then normal traffic resumes.
    txn(1'b0, 4'hF, 32'h3000_0030, 32'h0, 1000, 0, d, e, len);
    check("to_err", e, 1);
    check("to_dat", d, 32'h0);
    check("to_len", len, 8);
    txn(1'b1, 4'h3, 32'h3000_0030, 32'h1234_BEEF, 0, 0, d, e, len);
    check("after_to_err", e, 0);
    txn(1'b0, 4'hF, 32'h3000_0030, 32'h0, 0, 0, d, e, len);
    check("after_to_rd", d[15:0], 16'hBEEF);

    // Ack on the very last allowed cycle wins; one cycle later it is too late.
    txn(1'b0, 4'hF, 32'h3000_0018, 32'h0, TIMEOUT - 1, 0, d, e, len);
    check("late_ack_err", e, 0);
    check("late_ack_len", len, 8);
    txn(1'b1, 4'hF, 32'h3000_0018, 32'hDEAD_BEEF, TIMEOUT, 0, d, e, len);
    check("miss_ack_err", e, 1);
    check("miss_ack_len", len, 8);

    // Response backpressure with spurious acks.
    mem[7] = 32'h0BAD_F00D; ref_mem[7] = 32'h0BAD_F00D;
    txn(1'b0, 4'hF, 32'h3000_001C, 32'h0, 1, 5, d, e, len);
    check("bp_rd_dat", d, 32'h0BAD_F00D);

    // Reset on the second wait cycle abandons the access.
    slv_wait = 20; rsp_ready = 1'b0;
    send_cmd(1'b0, 4'hF, 32'h3000_0020, 32'h0, 1'b0, acc);
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0; force_ack = 1'b1;
    @(negedge clk);
    check("mid_rst_cyc", cyc, 0);
    check("mid_rst_stb", stb, 0);
    check("mid_rst_rsp_valid", rsp_valid, 0);
    check("mid_rst_cmd_ready", cmd_ready, 1);
    @(posedge clk); #1;
    force_ack = 1'b0;
    @(negedge clk);
    check("stray_ack_cyc", cyc, 0);
    check("stray_ack_rsp_valid", rsp_valid, 0);
    check("stray_ack_cmd_ready", cmd_ready, 1);
    @(posedge clk); #1;

    // Back-to-back zero-wait reads with the response side always ready.
    slv_wait = 0; rsp_ready = 1'b1; rsp_log.delete();
    for (int i = 0; i < 4; i++) begin
      bidx[i] = 8 + 3 * i;
      send_cmd(1'b0, 4'hF, 32'h3000_0000 | (32'(bidx[i]) << 2), $urandom, i < 3, bacc[i]);
    end
    repeat (3) @(posedge clk);
    #1 rsp_ready = 1'b0;
    check("b2b_count", rsp_log.size(), 4);
    for (int i = 0; i < 4; i++) begin
      if (i < rsp_log.size()) begin
        check("b2b_dat", rsp_log[i].d, ref_mem[bidx[i]]);
        check("b2b_err", rsp_log[i].e, 0);
        if (i > 0) check("b2b_spacing", rsp_log[i].at - rsp_log[i-1].at, 3);
      end
      if (i > 0) check("b2b_accept_spacing", bacc[i] - bacc[i-1], 3);
    end

    // Random traffic: idle gaps with junk commands and stray acks, then one transaction.
    for (int t = 0; t < 40; t++) begin
      repeat ($urandom_range(0, 2)) begin
        cmd_valid = 1'b0; cmd_we = 1'($urandom); cmd_sel = 4'($urandom);
        cmd_adr = $urandom; cmd_dat = $urandom;
        spur_ack = 1'($urandom_range(0, 1));
        @(posedge clk); #1;
      end
      spur_ack = 1'b0;
      rw   = 1'($urandom_range(0, 1));
      rs   = 4'($urandom_range(1, 15));
      idx  = $urandom_range(0, 15);
      r    = $urandom_range(0, 9);
      wsel = (r < 6) ? $urandom_range(0, 3) : (r < 8) ? TIMEOUT - 1 : TIMEOUT + $urandom_range(0, 2);
      txn(rw, rs, 32'h3000_0000 | (32'(idx) << 2), $urandom, wsel, $urandom_range(0, 3), d, e, len);
    end

    repeat (2) @(posedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
